// File: rtl/shift_pkg.sv
// Shared definitions for the serial frame controller: FSM encoding and default sizing.
package shift_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDiv   = 4;

endpackage

// File: rtl/shift_tick_gen.sv
// Bit-tick divider: while run is high, tick pulses once every DIV clocks.
module shift_tick_gen
    import shift_pkg::*;
#(
    parameter int unsigned DIV = DefDiv
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick      = run && (div_cnt_q == CntMax);
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (run) begin
            // Wrap at the terminal count so the counter never runs past DIV-1.
            div_cnt_d = tick ? '0 : div_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/shift_frame_ctrl.sv
// Sequences one serial frame: loads a word, shifts it out MSB first while capturing ser_in,
// then presents the captured word with a one-cycle rx_valid strobe.
module shift_frame_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DIV   = DefDiv
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             shift_en,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tick_clear;
    logic             tick_run;
    logic             tick;

    shift_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tick_clear),
        .run   (tick_run),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tick_clear  = 1'b0;
        tick_run    = (state_q == StShift);
        start_ready = (state_q == StIdle);
        busy        = (state_q != StIdle);
        ser_out     = 1'b0;
        shift_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // abort is ignored here so a same-cycle start always wins.
                if (start_valid) begin
                    sreg_d     = tx_data;
                    bit_cnt_d  = '0;
                    tick_clear = 1'b1;
                    state_d    = StShift;
                end
            end
            StShift: begin
                ser_out = sreg_q[WIDTH-1];
                if (abort) begin
                    tick_clear = 1'b1;
                    state_d    = StIdle;
                end else if (tick) begin
                    shift_en  = 1'b1;
                    sreg_d    = {sreg_q[WIDTH-2:0], ser_in};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == LastBit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                rx_data_d  = sreg_q;
                rx_valid_d = 1'b1;
                state_d    = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Scoreboard bench for shift_frame_ctrl: one DIV=4 instance and one DIV=1 instance.
module tb_shift_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DIV = 4 instance
    logic       a_sv, a_rdy, a_abort, a_sin, a_sout, a_sen, a_busy, a_rxv, loop_a;
    logic [7:0] a_tx, a_rx;
    assign a_sin = loop_a ? a_sout : 1'b1;

    // DIV = 1 instance, always looped back
    logic       b_sv, b_rdy, b_abort, b_sin, b_sout, b_sen, b_busy, b_rxv;
    logic [7:0] b_tx, b_rx;
    assign b_sin = b_sout;

    shift_frame_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (a_sv),
        .start_ready (a_rdy),
        .tx_data     (a_tx),
        .abort       (a_abort),
        .ser_in      (a_sin),
        .ser_out     (a_sout),
        .shift_en    (a_sen),
        .busy        (a_busy),
        .rx_data     (a_rx),
        .rx_valid    (a_rxv)
    );

    shift_frame_ctrl #(.WIDTH(8), .DIV(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (b_sv),
        .start_ready (b_rdy),
        .tx_data     (b_tx),
        .abort       (b_abort),
        .ser_in      (b_sin),
        .ser_out     (b_sout),
        .shift_en    (b_sen),
        .busy        (b_busy),
        .rx_data     (b_rx),
        .rx_valid    (b_rxv)
    );

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } exp_t;

    exp_t rxq_a[$];
    exp_t tkq_a[$];
    exp_t rxq_b[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops an expectation whenever a DUT presents rx_valid or shift_en.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (a_rxv) begin
                if (rxq_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_rx_unexpected: rx_valid with data 0x%0h at cycle %0d", a_rx, cyc);
                end else begin
                    e = rxq_a.pop_front();
                    chk("a_rx_data", 32'(a_rx), 32'(e.data));
                    chk("a_rx_cycle", cyc, e.cyc);
                end
            end
            if (a_sen) begin
                if (tkq_a.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL a_tick_unexpected: shift_en at cycle %0d", cyc);
                end else begin
                    e = tkq_a.pop_front();
                    chk("a_tick_ser_out", 32'(a_sout), 32'(e.data[0]));
                    chk("a_tick_cycle", cyc, e.cyc);
                end
            end
            if (b_rxv) begin
                if (rxq_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_rx_unexpected: rx_valid with data 0x%0h at cycle %0d", b_rx, cyc);
                end else begin
                    e = rxq_b.pop_front();
                    chk("b_rx_data", 32'(b_rx), 32'(e.data));
                    chk("b_rx_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called just after a negedge; returns the accept cycle index.
    task automatic send_a(input logic [7:0] d, input int nt, input bit full,
                          input logic [7:0] rx_exp, output int unsigned a);
        a_sv = 1'b1;
        a_tx = d;
        chk("a_ready_before_start", 32'(a_rdy), 32'd1);
        @(posedge clk);
        #1 a = cyc;
        for (int i = 0; i < nt; i++) begin
            tkq_a.push_back('{data: {7'b0, d[7-i]}, cyc: a + 32'(4 * i + 3)});
        end
        if (full) rxq_a.push_back('{data: rx_exp, cyc: a + 33});
        @(negedge clk);
        a_sv = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, output int unsigned a);
        b_sv = 1'b1;
        b_tx = d;
        for (int k = 0; k < 50 && !b_rdy; k++) @(negedge clk);
        chk("b_ready_wait", 32'(b_rdy), 32'd1);
        @(posedge clk);
        #1 a = cyc;
        rxq_b.push_back('{data: d, cyc: a + 9});
        @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200; k++) begin
            if (rxq_a.size() == 0 && rxq_b.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", rxq_a.size() + rxq_b.size(), 32'd0);
    endtask

    int unsigned a0, a1, a2;

    initial begin
        a_sv = 1'b0; a_tx = '0; a_abort = 1'b0; loop_a = 1'b1;
        b_sv = 1'b0; b_tx = '0; b_abort = 1'b0;

        // Reset values
        #1;
        chk("reset_outs_a", 32'({a_rdy, a_sout, a_sen, a_busy, a_rxv}), 32'b10000);
        chk("reset_rx_a", 32'(a_rx), 32'd0);
        chk("reset_outs_b", 32'({b_rdy, b_sout, b_sen, b_busy, b_rxv}), 32'b10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a frame
        send_a(8'h5A, 8, 1'b1, 8'h5A, a0);
        repeat (5) @(negedge clk);
        chk("busy_before_reset", 32'(a_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_outs", 32'({a_rdy, a_sout, a_sen, a_busy, a_rxv}), 32'b10000);
        chk("midrun_reset_rx", 32'(a_rx), 32'd0);
        rxq_a.delete();
        tkq_a.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback A5
        send_a(8'hA5, 8, 1'b1, 8'hA5, a0);
        wait_drain();
        repeat (3) @(negedge clk);

        // ser_in tied high, 00 out, ignored start mid-frame
        loop_a = 1'b0;
        send_a(8'h00, 8, 1'b1, 8'hFF, a0);
        while (cyc < a0 + 10) @(negedge clk);
        chk("ready_low_while_busy", 32'(a_rdy), 32'd0);
        a_sv = 1'b1;
        a_tx = 8'h55;
        @(negedge clk);
        a_sv = 1'b0;
        wait_drain();
        repeat (40) @(negedge clk);
        loop_a = 1'b1;

        // Abort after the third tick
        send_a(8'h3C, 3, 1'b0, 8'h00, a0);
        while (cyc < a0 + 13) @(negedge clk);
        chk("pre_abort_ser_out", 32'(a_sout), 32'd1);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("abort_to_idle", 32'({a_rdy, a_busy, a_sout}), 32'b100);
        chk("abort_rx_kept", 32'(a_rx), 32'hFF);
        repeat (10) @(negedge clk);
        chk("abort_no_rx", 32'(a_rx), 32'hFF);
        send_a(8'hC3, 8, 1'b1, 8'hC3, a0);
        wait_drain();

        // DIV=1 back-to-back requests
        send_b(8'h01, a1);
        send_b(8'h80, a2);
        b_sv = 1'b0;
        chk("b_frame_spacing", a2 - a1, 32'd10);
        wait_drain();
        repeat (5) @(negedge clk);

        chk("tick_queue_empty", tkq_a.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
